vocoder_band_mixer: RTL and testbench

//  Channel-vocoder synthesis stage; sits directly downstream of the two-pass mel filterbank sequencer.
//  Per frame it tracks each modulator (mic) band envelope and scales the matching carrier (mem) band by it.
//  It sums all bands into one saturated PCM sample for the audio output path.
//  One shared multiplier, bands processed serially; a frame finishes well inside the 100-cycle sample slot.

---
 rtl/vocoder_band_mixer_pkg.sv | 26 ++
 rtl/vocoder_band_mixer_if.sv | 31 +++
 rtl/vocoder_band_mixer_env_follower.sv | 33 +++
 rtl/vocoder_band_mixer.sv | 118 +++++++++++
 tb/tb_vocoder_band_mixer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vocoder_band_mixer_pkg.sv
// Shared types and helpers for the vocoder band mixer.
//   NUM_BANDS     : number of filterbank bands in each input vector
//   sample_t      : 16-bit signed PCM / band sample
//   band_vec_t    : one filterbank vector (NUM_BANDS samples)
//   mixer_state_t : frame sequencer states
//   sat16()       : clamp a 21-bit accumulator value to the 16-bit PCM range
package vocoder_band_mixer_pkg;

    localparam int NUM_BANDS = 15;

    typedef logic signed [15:0] sample_t;
    typedef sample_t band_vec_t [NUM_BANDS];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} mixer_state_t;

    function automatic sample_t sat16(input logic signed [20:0] x);
        if (x > 21'sd32767) begin
            return 16'sh7fff;
        end else if (x < -21'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/vocoder_band_mixer_if.sv
// Frame handshake bundle between the filterbank sequencer and the band mixer.
//   valid_in  : 1-cycle pulse, mic_bands/mem_bands hold a new frame
//   mic_bands : modulator (mic) band vector
//   mem_bands : carrier band vector
//   pcm_out   : vocoded sample, held until the next frame completes
//   valid_out : 1-cycle pulse when pcm_out updates
//   busy      : mixer is walking the bands (RUN/DRAIN)
//   overrun   : sticky, a frame was offered while busy
// master drives frames (upstream side), slave is the mixer.
interface vocoder_band_mixer_if;
    import vocoder_band_mixer_pkg::*;

    logic      valid_in;
    band_vec_t mic_bands;
    band_vec_t mem_bands;
    sample_t   pcm_out;
    logic      valid_out;
    logic      busy;
    logic      overrun;

    modport master (
        output valid_in, mic_bands, mem_bands,
        input  pcm_out, valid_out, busy, overrun
    );

    modport slave (
        input  valid_in, mic_bands, mem_bands,
        output pcm_out, valid_out, busy, overrun
    );

endinterface

// File: rtl/vocoder_band_mixer_env_follower.sv
// Combinational single-band envelope update.
//   mic           : modulator band sample
//   env           : current envelope, unsigned Q0.15
//   attack_shift  : rise coefficient exponent (env moves by 2^-attack_shift of the gap)
//   release_shift : fall coefficient exponent
//   env_new       : updated envelope, always within 0..32767
module vocoder_env_follower
    import vocoder_band_mixer_pkg::*;
(
    input  sample_t     mic,
    input  logic [14:0] env,
    input  logic [3:0]  attack_shift,
    input  logic [3:0]  release_shift,
    output logic [14:0] env_new
);

    logic signed [16:0] mag;
    logic [14:0]        a;
    logic signed [16:0] d;
    logic signed [16:0] step;

    always_comb begin
        // 17 bits so |-32768| is representable before clamping
        mag  = mic[15] ? -$signed({mic[15], mic}) : $signed({mic[15], mic});
        a    = (mag > 17'sd32767) ? 15'h7fff : mag[14:0];
        d    = $signed({2'b00, a}) - $signed({2'b00, env});
        // Arithmetic shift floors toward -inf, so a falling envelope never
        // undershoots the target and a rising one never overshoots it.
        step = (d > 17'sd0) ? (d >>> attack_shift) : (d >>> release_shift);
        env_new = 15'($signed({2'b00, env}) + step);
    end

endmodule

// File: rtl/vocoder_band_mixer.sv
// Channel-vocoder synthesis stage. Each frame walks the bands serially with a
// single shared multiplier: the modulator envelope of band k scales carrier
// band k, the scaled bands are summed and the sum is saturated to one PCM
// sample. valid_out follows the accepting edge by NUM_BANDS+2 edges.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : frame handshake (slave side), see vocoder_band_mixer_if
module vocoder_band_mixer
    import vocoder_band_mixer_pkg::*;
#(
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 6,
    parameter int OUT_SHIFT     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vocoder_band_mixer_if.slave  bus
);

    localparam int            KW     = $clog2(NUM_BANDS);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_BANDS - 1);

    mixer_state_t       state, state_nxt;
    logic               accept;
    logic [KW-1:0]      k;
    band_vec_t          mic_q, mem_q;
    logic [14:0]        env [NUM_BANDS];
    logic [14:0]        env_new;
    logic signed [31:0] prod_p1;
    logic               vld_p1;
    logic signed [20:0] acc;

    vocoder_env_follower u_env (
        .mic           (mic_q[k]),
        .env           (env[k]),
        .attack_shift  (4'(ATTACK_SHIFT)),
        .release_shift (4'(RELEASE_SHIFT)),
        .env_new       (env_new)
    );

    // A frame may be accepted in FINISH as well as IDLE, which gives
    // back-to-back frames every NUM_BANDS+2 cycles.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (k == K_LAST) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = FINISH;
            FINISH: begin
                if (bus.valid_in) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            vld_p1        <= 1'b0;
            acc           <= '0;
            bus.pcm_out   <= '0;
            bus.valid_out <= 1'b0;
            bus.overrun   <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) env[i] <= '0;
        end else begin
            state         <= state_nxt;
            bus.valid_out <= 1'b0;
            if (bus.valid_in && bus.busy) bus.overrun <= 1'b1;

            // stage 1: envelope update for band k, product registered below
            vld_p1 <= (state == RUN);
            if (state == RUN) begin
                env[k] <= env_new;
                k      <= k + KW'(1);
            end

            // stage 2: accumulate the product of the previous band
            if (accept) begin
                k   <= '0;
                acc <= '0;
            end else if (vld_p1) begin
                acc <= acc + 21'(prod_p1 >>> 15);
            end

            // finish: scale, saturate and publish
            if (state == FINISH) begin
                bus.pcm_out   <= sat16(acc >>> OUT_SHIFT);
                bus.valid_out <= 1'b1;
            end
        end
    end

    // Capture and product registers carry data only.
    always_ff @(posedge clk) begin
        if (accept) begin
            mic_q <= bus.mic_bands;
            mem_q <= bus.mem_bands;
        end
        prod_p1 <= 32'(mem_q[k]) * 32'($signed({1'b0, env_new}));
    end

endmodule

// File: tb/tb_vocoder_band_mixer.sv
// Self-checking bench for vocoder_band_mixer: a frame-level behavioural model
// predicts pcm_out, valid_out timing, busy and overrun; one compare process
// checks them every cycle, and literal expectations pin the model.
module tb_vocoder_band_mixer;
    import vocoder_band_mixer_pkg::*;

    localparam int NB = NUM_BANDS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vocoder_band_mixer_if bus ();

    vocoder_band_mixer #(
        .ATTACK_SHIFT  (2),
        .RELEASE_SHIFT (6),
        .OUT_SHIFT     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // model state
    int m_env [NB];
    int mic_v [NB];
    int mem_v [NB];
    int exp_q_edge [$];
    int exp_q_pcm  [$];
    int last_acc = -1000;
    int ovr_edge = 1 << 30;
    int exp_pcm  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One whole frame from the rules: envelope per band, weighted sum, shift, clamp.
    function automatic int model_frame();
        int sum = 0;
        for (int b = 0; b < NB; b++) begin
            int a, d;
            a = (mic_v[b] < 0) ? -mic_v[b] : mic_v[b];
            if (a > 32767) a = 32767;
            d = a - m_env[b];
            m_env[b] += (d > 0) ? (d >>> 2) : (d >>> 6);
            sum += (mem_v[b] * m_env[b]) >>> 15;
        end
        sum = sum >>> 2;
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
        return sum;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // compare process
    initial forever begin
        logic exp_v, exp_b, exp_o;
        @(negedge clk);
        exp_v = (exp_q_edge.size() > 0) && (exp_q_edge[0] == cyc);
        if (exp_v) begin
            exp_pcm = exp_q_pcm.pop_front();
            void'(exp_q_edge.pop_front());
        end
        exp_b = (cyc >= last_acc) && (cyc <= last_acc + 15);
        exp_o = (cyc >= ovr_edge);
        check("valid_out", int'(bus.valid_out), int'(exp_v));
        check("pcm_out",   int'(bus.pcm_out),   exp_pcm);
        check("busy",      int'(bus.busy),      int'(exp_b));
        check("overrun",   int'(bus.overrun),   int'(exp_o));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one valid_in pulse; the model decides acceptance from frame timing.
    task automatic offer();
        int e;
        e = cyc + 1;
        for (int b = 0; b < NB; b++) begin
            bus.mic_bands[b] = sample_t'(mic_v[b]);
            bus.mem_bands[b] = sample_t'(mem_v[b]);
        end
        bus.valid_in = 1'b1;
        if ((e - 1 >= last_acc) && (e - 1 <= last_acc + 15)) begin
            if (e < ovr_edge) ovr_edge = e;
        end else begin
            exp_q_edge.push_back(e + 17);
            exp_q_pcm.push_back(model_frame());
            last_acc = e;
        end
        step(1);
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) begin
                lat = cyc - last_acc;
                break;
            end
            step(1);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_env[b] = 0;
        exp_q_edge.delete();
        exp_q_pcm.delete();
        last_acc = -1000;
        ovr_edge = 1 << 30;
        exp_pcm  = 0;
    endtask

    task automatic set_all(input int mic, input int mem);
        for (int b = 0; b < NB; b++) begin
            mic_v[b] = mic;
            mem_v[b] = mem;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, prev, cur, c1, pulses;
        bus.valid_in = 1'b0;
        set_all(0, 0);
        for (int b = 0; b < NB; b++) begin
            bus.mic_bands[b] = '0;
            bus.mem_bands[b] = '0;
        end
        model_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check("reset_pcm", int'(bus.pcm_out), 0);
        check("reset_overrun", int'(bus.overrun), 0);
        step(2);

        // attack from zero
        set_all(16384, 0);
        offer();
        wait_out(lat);
        check("attack_latency", lat, 17);
        check("attack_env0_model", m_env[0], 4096);
        check("attack_env0_dut", int'(dut.env[0]), 4096);
        check("attack_pcm", int'(bus.pcm_out), 0);
        step(3);

        // steady state, frames back to back through FINISH
        set_all(32767, 0);
        mem_v[0] = 16384;
        repeat (40) begin
            offer();
            step(16);
        end
        step(1);
        check("steady_pcm", int'(bus.pcm_out), 4095);
        check("steady_env0_within4", int'((32767 - int'(dut.env[0])) <= 4), 1);
        check("steady_env0_model", m_env[0], 32764);
        step(2);

        // release, monotone decay
        for (int b = 0; b < NB; b++) mic_v[b] = 0;
        offer();
        step(17);
        check("release_env0", int'(dut.env[0]), 32252);
        prev = int'(dut.env[0]);
        repeat (5) begin
            offer();
            step(17);
            cur = int'(dut.env[0]);
            check("release_monotone", int'(cur < prev), 1);
            check("release_env0_model", cur, m_env[0]);
            prev = cur;
        end

        // saturation both ways
        set_all(32767, 32767);
        repeat (40) begin
            offer();
            step(16);
        end
        step(1);
        check("sat_pos_pcm", int'(bus.pcm_out), 32767);
        step(2);
        set_all(32767, -32768);
        offer();
        step(17);
        check("sat_neg_pcm", int'(bus.pcm_out), -32768);
        step(2);

        // randomized frames with random spacing (some land while busy)
        repeat (60) begin
            for (int b = 0; b < NB; b++) begin
                mic_v[b] = int'($urandom_range(0, 65535)) - 32768;
                mem_v[b] = int'($urandom_range(0, 65535)) - 32768;
            end
            if ($urandom_range(0, 7) == 0) mic_v[$urandom_range(0, NB - 1)] = -32768;
            offer();
            step(int'($urandom_range(10, 20)));
        end
        step(25);

        // reset in the middle of a frame
        set_all(20000, 12000);
        offer();
        step(4);
        rst = 1'b1;
        model_reset();
        step(1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.valid_out), 0);
        check("midrst_pcm", int'(bus.pcm_out), 0);
        check("midrst_overrun", int'(bus.overrun), 0);
        check("midrst_env0", int'(dut.env[0]), 0);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            step(1);
            if (bus.valid_out) pulses++;
        end
        check("midrst_no_valid", pulses, 0);

        // drop while busy
        set_all(20000, 1000);
        offer();
        step(4);
        offer();
        wait_out(lat);
        check("hs_latency", lat, 17);
        check("hs_overrun", int'(bus.overrun), 1);
        pulses = 0;
        repeat (20) begin
            step(1);
            if (bus.valid_out) pulses++;
        end
        check("hs_single_valid", pulses, 0);

        // accept in FINISH: outputs 17 cycles apart
        set_all(-9000, 30000);
        offer();
        step(16);
        offer();
        check("b2b_first_valid", int'(bus.valid_out), 1);
        c1 = cyc;
        step(1);
        wait_out(lat);
        check("b2b_spacing", cyc - c1, 17);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
